// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Iteration counter width: must hold the value n itself.
   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/full_subtractor_nb.sv
// Combinational n-bit subtractor: {bout, diff} = a - b - bin.
module full_subtractor_nb #(
   parameter int n = 9
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         bin,
   output logic [n-1:0] diff,
   output logic         bout
);

   logic [n:0] wide;

   always_comb begin
      wide = {1'b0, a} - {1'b0, b} - {{n{1'b0}}, bin};
      diff = wide[n-1:0];
      bout = wide[n];
   end

endmodule

// File: rtl/restoring_divider_nb.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per cycle.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting/subtracting, cnt iterations remain
// DONE  | results valid, done pulse; may accept a new start
module restoring_divider_nb
   import div_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = cnt_w(N);

   state_t        state;
   state_t        state_nx;
   logic [N:0]    r;
   logic [N-1:0]  q;
   logic [N-1:0]  d;
   logic [CW-1:0] cnt;

   logic [N:0]    shifted;
   logic [N:0]    diff;
   logic          bout;
   logic [N:0]    r_nx;
   logic [N-1:0]  q_nx;
   logic          accept;
   logic          zero_div;
   logic          last_iter;
   logic          unused_r_msb;

   // R never exceeds the divisor, so its top bit is only headroom for the shift.
   assign unused_r_msb = r[N];

   assign shifted   = {r[N-1:0], q[N-1]};
   assign accept    = start && (state != RUN);
   assign zero_div  = (divisor == '0);
   assign last_iter = (cnt == CW'(1));

   full_subtractor_nb #(.n(N+1)) u_sub (
      .a    (shifted),
      .b    ({1'b0, d}),
      .bin  (1'b0),
      .diff (diff),
      .bout (bout)
   );

   always_comb begin
      r_nx = bout ? shifted : diff;
      q_nx = {q[N-2:0], ~bout};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) state_nx = zero_div ? DONE : RUN;
            else       state_nx = IDLE;
         end
         RUN:     state_nx = last_iter ? DONE : RUN;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r           <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         if (zero_div) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            r   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= CW'(N);
         end
      end else if (state == RUN) begin
         r   <= r_nx;
         q   <= q_nx;
         cnt <= cnt - CW'(1);
         if (last_iter) begin
            quotient    <= q_nx;
            remainder   <= r_nx[N-1:0];
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_restoring_divider_nb.sv
// Directed and random checks of restoring_divider_nb at N=8.
module tb_restoring_divider_nb;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int n_chk  = 0;
   int n_pass = 0;

   restoring_divider_nb #(.N(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Called at the negedge just after the accepting edge; returns edges until done.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez,
                         input int elat);
      int lat, bcnt;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt);
      check({tag, "_lat"},  lat, elat);
      check({tag, "_busy"}, bcnt, elat);
      check({tag, "_q"},    quotient, eq);
      check({tag, "_r"},    remainder, er);
      check({tag, "_dbz"},  div_by_zero, ez);
      @(negedge clk);
      check({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      int lat, bcnt, dcnt;
      logic [7:0] ra, rb;

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q",    quotient, 0);
      check("rst_r",    remainder, 0);
      check("rst_dbz",  div_by_zero, 0);
      rst_n = 1'b1;

      run_op("t1_100_7",  8'd100, 8'd7, 8'd14,  8'd2,  1'b0, 8);
      run_op("t2_5_9",    8'd5,   8'd9, 8'd0,   8'd5,  1'b0, 8);
      run_op("t2_255_1",  8'd255, 8'd1, 8'd255, 8'd0,  1'b0, 8);
      run_op("t3_77_0",   8'd77,  8'd0, 8'd255, 8'd77, 1'b1, 0);

      // Start pulsed mid-RUN must be ignored and outputs must hold.
      @(negedge clk);
      start = 1'b1; dividend = 8'd200; divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; dividend = 8'd9; divisor = 8'd2;
      @(negedge clk);
      start = 1'b0;
      check("t4_hold_q",   quotient, 255);
      check("t4_hold_r",   remainder, 77);
      check("t4_busy",     busy, 1);
      wait_done(lat, bcnt);
      check("t4_lat", lat + 3, 8);
      check("t4_q", quotient, 66);
      check("t4_r", remainder, 2);
      check("t4_dbz", div_by_zero, 0);
      @(negedge clk);

      // Start held high through DONE: back-to-back accept.
      @(negedge clk);
      start = 1'b1; dividend = 8'd200; divisor = 8'd3;
      @(negedge clk);
      dividend = 8'd250; divisor = 8'd16;
      wait_done(lat, bcnt);
      check("t5a_lat", lat, 8);
      check("t5a_q", quotient, 66);
      check("t5a_r", remainder, 2);
      @(negedge clk);
      start = 1'b0;
      check("t5_reaccept_busy", busy, 1);
      wait_done(lat, bcnt);
      check("t5_gap", lat + 1, 9);
      check("t5b_q", quotient, 15);
      check("t5b_r", remainder, 10);
      @(negedge clk);

      // Reset in the middle of RUN aborts the operation.
      @(negedge clk);
      start = 1'b1; dividend = 8'd50; divisor = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_q",    quotient, 0);
      check("t6_r",    remainder, 0);
      check("t6_dbz",  div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("t6_no_done", dcnt, 0);
      run_op("t6_10_3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 8);

      for (int i = 0; i < 10; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = (i == 4) ? 8'd0 : 8'($urandom_range(1, 255));
         if (rb == 8'd0) run_op("rnd", ra, rb, 8'd255, ra, 1'b1, 0);
         else            run_op("rnd", ra, rb, ra / rb, ra % rb, 1'b0, 8);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
